// File: rtl/cu_fft_stage.sv
// cu_fft_stage: sequencer for one FFT stage.
// Turns a frame-start pulse from the previous stage into the butterfly
// enable, the twiddle multiplier enable with its ROM address, and a delayed
// frame-start pulse for the next stage. Every output is a register.
module cu_fft_stage #(
    parameter int FRAME_LEN = 32,
    parameter int ADDR_W    = 9,
    parameter int ADDR_BASE = 0,
    parameter int ADDR_STEP = 1,
    parameter int MUL_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alert_in,
    output logic              bf_en,
    output logic              mul_en,
    output logic [ADDR_W-1:0] addr,
    output logic              alert_out,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              overrun_err
);

    localparam int                BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST   = BEAT_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                bf_en_q;
    logic                busy_q;
    logic                mul_en_q, mul_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                overrun_q, overrun_d;
    logic                alert_out_q, alert_out_d;
    // One bit per accepted frame start still travelling toward alert_out.
    logic [MUL_LAT:0]    vld_pipe_q, vld_pipe_d;
    logic                accept;
    logic                pending;

    // A start pulse is taken unless a frame is mid-flight (last beat excepted).
    always_comb begin
        accept      = alert_in && ((state_q != RUN) || (beat_q == LAST));
        pending     = |vld_pipe_q;
        vld_pipe_d  = {vld_pipe_q[MUL_LAT-1:0], accept};
        alert_out_d = vld_pipe_q[MUL_LAT];
        mul_en_d    = bf_en_q;
        // Multiplier beat k follows butterfly beat k by one cycle.
        addr_d      = BASE;
        if (bf_en_q)
            addr_d = (beat_q == '0) ? BASE : addr_q + STEP;
        frame_cnt_d = accept ? frame_cnt_q + 8'd1 : frame_cnt_q;
        overrun_d   = overrun_q | (alert_in & ~accept);
    end

    // Frame sequencer: state, beat counter, butterfly enable and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            bf_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        beat_q  <= '0;
                        bf_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat_q == LAST) begin
                        beat_q <= '0;
                        if (accept) begin
                            // Chained frame: no bubble in bf_en.
                            bf_en_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            bf_en_q <= 1'b0;
                        end
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_q <= RUN;
                        beat_q  <= '0;
                        bf_en_q <= 1'b1;
                    end else if (!mul_en_q && !pending) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                    bf_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers: multiplier side, alert delay line, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_en_q    <= 1'b0;
            addr_q      <= BASE;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            alert_out_q <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            mul_en_q    <= mul_en_d;
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            alert_out_q <= alert_out_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign bf_en       = bf_en_q;
    assign mul_en      = mul_en_q;
    assign addr        = addr_q;
    assign alert_out   = alert_out_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_cu_fft_stage.sv
// Bench for cu_fft_stage: frame-level model checked every cycle against the
// default instance, plus directed literal checks on both instances.
module tb_cu_fft_stage;

    localparam int FL = 32;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alert_in = 1'b0;

    logic       bf_en, mul_en, alert_out, busy, overrun_err;
    logic [8:0] addr;
    logic [7:0] frame_cnt;

    logic       bf_en_b, mul_en_b, alert_out_b, busy_b, overrun_err_b;
    logic [8:0] addr_b;
    logic [7:0] frame_cnt_b;

    cu_fft_stage dut (
        .clk(clk), .rst(rst), .alert_in(alert_in),
        .bf_en(bf_en), .mul_en(mul_en), .addr(addr), .alert_out(alert_out),
        .busy(busy), .frame_cnt(frame_cnt), .overrun_err(overrun_err)
    );

    cu_fft_stage #(.FRAME_LEN(8), .ADDR_W(9), .ADDR_BASE(500), .ADDR_STEP(4), .MUL_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .alert_in(alert_in),
        .bf_en(bf_en_b), .mul_en(mul_en_b), .addr(addr_b), .alert_out(alert_out_b),
        .busy(busy_b), .frame_cnt(frame_cnt_b), .overrun_err(overrun_err_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at rel cycle %0d: got %0d expected %0d", nm, cyc - base, got, exp);
        end
    endtask

    // Frame-level model: a frame accepted at cycle T occupies T+1..T+FL on the
    // butterfly, T+2..T+FL+1 on the multiplier, and fires alert_out at T+2+ML.
    int m_bf, m_mul, m_addr, m_ao, m_busy, m_fcnt, m_ovr;
    int start = -1000, run_end = -1000;
    int ao_q[$];

    always @(posedge clk) begin : model
        int c, prev_beat, prev_bf, prev_mul;
        bit running, acc, pend;
        c = cyc + 1;
        if (rst) begin
            m_bf = 0; m_mul = 0; m_addr = 0; m_ao = 0; m_busy = 0;
            m_fcnt = 0; m_ovr = 0; start = -1000; run_end = -1000;
            ao_q.delete();
        end else begin
            running   = (cyc >= start) && (cyc <= run_end);
            prev_beat = cyc - start;
            prev_bf   = m_bf;
            prev_mul  = m_mul;
            pend      = (ao_q.size() != 0);
            acc       = 1'b0;
            if (alert_in) begin
                if (!running || cyc == run_end) acc = 1'b1;
                else m_ovr = 1;
            end
            if (acc) begin
                start   = c;
                run_end = cyc + FL;
                m_fcnt  = (m_fcnt + 1) % 256;
                ao_q.push_back(cyc + 2 + ML);
            end
            m_mul  = prev_bf;
            m_addr = m_mul ? (prev_beat % 512) : 0;
            m_bf   = (c >= start && c <= run_end) ? 1 : 0;
            m_ao   = 0;
            if (ao_q.size() != 0 && ao_q[0] == c) begin
                m_ao = 1;
                void'(ao_q.pop_front());
            end
            m_busy = (m_bf != 0 || (m_busy != 0 && (prev_bf != 0 || prev_mul != 0 || pend))) ? 1 : 0;
        end
        cyc = c;
    end

    // Every-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bf_en", int'(bf_en), m_bf);
            chk("mul_en", int'(mul_en), m_mul);
            chk("addr", int'(addr), m_addr);
            chk("alert_out", int'(alert_out), m_ao);
            chk("busy", int'(busy), m_busy);
            chk("frame_cnt", int'(frame_cnt), m_fcnt);
            chk("overrun_err", int'(overrun_err), m_ovr);
        end
    end

    task automatic wait_to(input int n);
        if (cyc - base > n) begin
            errors++;
            $display("FAIL wait_to target %0d already passed (now %0d)", n, cyc - base);
        end
        while (cyc - base < n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        wait_to(n);
        alert_in = 1'b1;
        @(negedge clk);
        alert_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        // Single frame
        do_reset();
        chk("rst_bf", int'(bf_en), 0);
        chk("rst_mul", int'(mul_en), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_ao", int'(alert_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fcnt", int'(frame_cnt), 0);
        chk("rst_ovr", int'(overrun_err), 0);
        chk("rst_addr_b", int'(addr_b), 500);
        pulse(10);
        wait_to(11); chk("s1_bf11", int'(bf_en), 1);
        wait_to(12); chk("s1_mul12", int'(mul_en), 1); chk("s1_addr12", int'(addr), 0);
        wait_to(14); chk("s1_ao14", int'(alert_out), 1); chk("s1_model_ao14", m_ao, 1);
        wait_to(42); chk("s1_bf42", int'(bf_en), 1);
        wait_to(43); chk("s1_bf43", int'(bf_en), 0); chk("s1_addr43", int'(addr), 31);
        chk("s1_model_addr43", m_addr, 31);
        wait_to(44); chk("s1_mul44", int'(mul_en), 0); chk("s1_busy44", int'(busy), 1);
        wait_to(45); chk("s1_busy45", int'(busy), 0); chk("s1_fcnt", int'(frame_cnt), 1);
        chk("s1_model_busy45", m_busy, 0);
        wait_to(60);

        // Back-to-back frames
        do_reset();
        pulse(10);
        pulse(42);
        wait_to(43); chk("s2_bf43", int'(bf_en), 1); chk("s2_addr43", int'(addr), 31);
        wait_to(44); chk("s2_addr44", int'(addr), 0);
        wait_to(46); chk("s2_ao46", int'(alert_out), 1);
        wait_to(50); chk("s2_fcnt", int'(frame_cnt), 2); chk("s2_ovr", int'(overrun_err), 0);
        wait_to(74); chk("s2_bf74", int'(bf_en), 1);
        wait_to(75); chk("s2_bf75", int'(bf_en), 0);
        wait_to(90);

        // Overrun
        do_reset();
        pulse(10);
        wait_to(20); chk("s3_ovr20", int'(overrun_err), 0);
        pulse(20);
        chk("s3_ovr21", int'(overrun_err), 1); chk("s3_fcnt21", int'(frame_cnt), 1);
        wait_to(24); chk("s3_ao24", int'(alert_out), 0);
        wait_to(42); chk("s3_bf42", int'(bf_en), 1);
        wait_to(43); chk("s3_bf43", int'(bf_en), 0);
        wait_to(60); chk("s3_ovr_sticky", int'(overrun_err), 1);

        // Restart from DRAIN
        do_reset();
        pulse(10);
        wait_to(43); chk("s4_bf43", int'(bf_en), 0);
        pulse(44);
        chk("s4_bf45", int'(bf_en), 1);
        wait_to(48); chk("s4_ao48", int'(alert_out), 1);
        wait_to(76); chk("s4_bf76", int'(bf_en), 1);
        wait_to(77); chk("s4_bf77", int'(bf_en), 0);
        wait_to(90);

        // Address wrap on the FRAME_LEN=8, base 500, step 4 instance
        do_reset();
        pulse(10);
        begin
            int exp_a [8] = '{500, 504, 508, 0, 4, 8, 12, 16};
            for (int k = 0; k < 8; k++) begin
                wait_to(12 + k);
                chk("s5_addr_b", int'(addr_b), exp_a[k]);
            end
        end
        wait_to(20); chk("s5_addr_b20", int'(addr_b), 500); chk("s5_mul_b20", int'(mul_en_b), 0);
        wait_to(60);

        // Reset mid-frame, with a coincident alert_in that must be ignored
        do_reset();
        pulse(10);
        wait_to(20);
        rst = 1'b1;
        alert_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        alert_in = 1'b0;
        chk("s6_bf21", int'(bf_en), 0); chk("s6_mul21", int'(mul_en), 0);
        chk("s6_busy21", int'(busy), 0); chk("s6_fcnt21", int'(frame_cnt), 0);
        wait_to(22); chk("s6_busy22", int'(busy), 0); chk("s6_bf22", int'(bf_en), 0);
        pulse(30);
        chk("s6_bf31", int'(bf_en), 1);
        wait_to(34); chk("s6_ao34", int'(alert_out), 1);
        wait_to(62); chk("s6_bf62", int'(bf_en), 1);
        wait_to(63); chk("s6_bf63", int'(bf_en), 0);
        wait_to(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_fft_stage.md
CU_FFT_STAGE -- requirements
Module: cu_fft_stage

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 32, meaning the number of bf_en beats per frame (range 2..256).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the twiddle address width.
REQ-003 SHALL have parameter ADDR_BASE, default 0, meaning the twiddle address on the first mul beat.
REQ-004 SHALL have parameter ADDR_STEP, default 1, meaning the address increment per mul beat.
REQ-005 SHALL have parameter MUL_LAT, default 2, meaning the cycles from mul_en to the first multiplier output (range 1..8).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port alert_in, input, 1 bit: a one-cycle pulse from the previous stage marking the first data beat of a frame.
REQ-009 SHALL have port bf_en, output, 1 bit: the butterfly bank enable.
REQ-010 SHALL have port mul_en, output, 1 bit: the twiddle multiplier enable.
REQ-011 SHALL have port addr, output, ADDR_W bits: the twiddle ROM address.
REQ-012 SHALL have port alert_out, output, 1 bit: a one-cycle pulse to the next stage marking its first valid beat.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port frame_cnt, output, 8 bits: the count of accepted frames, wrapping at 255->0.
REQ-015 SHALL have port overrun_err, output, 1 bit: a sticky error flag, cleared only by rst.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DRAIN.
- RUN: bf_en=1.
- DRAIN: bf_en=0, with mul_en or a pending alert_out still in flight.
REQ-017 SHALL keep a beat counter, 0..FRAME_LEN-1, that is active in RUN.
REQ-018 SHALL accept alert_in when the state is IDLE or DRAIN, or in RUN with beat==FRAME_LEN-1.
REQ-019 SHALL, when alert_in is accepted in cycle T, assert bf_en in cycles T+1..T+FRAME_LEN, with beat=0 at T+1.
REQ-020 SHALL increment frame_cnt by 1 in the cycle after each accepted alert_in.
REQ-021 SHALL, for an alert_in accepted on the last RUN beat, stay in RUN and reset beat to 0, giving gapless bf_en across frames.
REQ-022 SHALL, for alert_in in RUN with beat!=FRAME_LEN-1, ignore the pulse, leave the frame timing undisturbed, and set overrun_err.
REQ-023 SHALL have mul_en equal bf_en delayed by exactly 1 cycle.
REQ-024 SHALL drive addr as follows:
- addr=ADDR_BASE on the first mul beat of each frame;
- addr=ADDR_BASE+k*ADDR_STEP modulo 2^ADDR_W on mul beat k;
- addr=ADDR_BASE whenever mul_en=0.
REQ-025 SHALL pulse alert_out for exactly one cycle at T+2+MUL_LAT for each alert_in accepted at T; overlapping frames produce one pulse each, in order.
REQ-026 SHALL make the transitions:
- IDLE->RUN on an accepted alert_in;
- RUN->DRAIN after the last beat if no alert_in was accepted;
- DRAIN->RUN on an accepted alert_in;
- DRAIN->IDLE when mul_en=0 and no alert_out is pending.
REQ-027 SHALL register all outputs, with no combinational path from alert_in to any output.
REQ-028 SHALL ignore alert_in that is asserted in the same cycle as rst.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, set the following in the next cycle:
- state=IDLE, beat=0;
- bf_en=0, mul_en=0, addr=ADDR_BASE;
- alert_out=0, busy=0, frame_cnt=0, overrun_err=0;
- all pending alert_out pulses cleared.
REQ-030 SHALL abort a frame in progress when rst is asserted mid-frame, with no residual alert_out or enable after rst deasserts.

Verification
REQ-031 SHALL cover the single-frame case, with defaults and alert_in at cycle 10:
- bf_en high in cycles 11..42 and mul_en high in 12..43;
- addr 0..31 in cycles 12..43, then addr=0;
- alert_out at cycle 14, busy low from cycle 45, frame_cnt=1.
REQ-032 SHALL cover back-to-back frames, with alert_in at cycles 10 and 42:
- bf_en continuous over cycles 11..74;
- addr goes 31->0 at the cycle 43->44 boundary;
- alert_out at 14 and 46, frame_cnt=2, overrun_err=0.
REQ-033 SHALL cover overrun, with alert_in at 10 and 20:
- the second pulse is ignored and bf_en still ends at 42;
- overrun_err=1 from cycle 21 and frame_cnt=1;
- only one alert_out (at 14).
REQ-034 SHALL cover restart from DRAIN, with alert_in at 10 and 44:
- bf_en high 11..42, low at 43..44, high again 45..76;
- alert_out at 14 and 48.
REQ-035 SHALL cover address wrap, with ADDR_BASE=500, ADDR_STEP=4 and FRAME_LEN=8: addr sequence 500,504,508,0,4,8,12,16.
REQ-036 SHALL cover reset mid-frame, with alert_in at 10 and rst at 20:
- from 21, all outputs are at their reset values;
- no alert_out or enable appears before the next alert_in;
- a new alert_in at 30 yields bf_en at 31..62.
